// File: rtl/i2c_adc_target_if.sv
// ADC-side signals of the I2C ADC target: sample input toward the target,
// config byte and status pulses back out.
interface i2c_adc_target_if;
    logic [11:0] sample_data;
    logic [1:0]  sample_chan;
    logic [7:0]  config_byte;
    logic        config_valid;
    logic        sample_req;
    logic        busy;

    modport master (
        output sample_data,
        output sample_chan,
        input  config_byte,
        input  config_valid,
        input  sample_req,
        input  busy
    );

    modport slave (
        input  sample_data,
        input  sample_chan,
        output config_byte,
        output config_valid,
        output sample_req,
        output busy
    );
endinterface

// File: rtl/i2c_adc_target.sv
// I2C target emulating the board ADC: oversampled, glitch-filtered scl/sda decode,
// stores the written config byte and returns channel-tagged 12-bit samples on reads.
module i2c_adc_target #(
    parameter logic [6:0] DEV_ADDR    = 7'h28,
    parameter int         SYNC_STAGES = 2,
    parameter int         FILT_LEN    = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            scl,
    inout  wire             sda,
    i2c_adc_target_if.slave adc
);

    typedef enum logic [2:0] {
        IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, IGNORE
    } state_t;

    logic [1:0]  line_raw;
    logic [1:0]  line_f;
    logic        scl_f;
    logic        sda_f;
    logic        scl_prev_reg;
    logic        sda_prev_reg;
    logic        scl_rise;
    logic        scl_fall;
    logic        start_det;
    logic        stop_det;

    state_t      state_reg;
    logic [3:0]  bit_cnt_reg;
    logic [7:0]  shift_reg;
    logic [7:0]  shift_next;
    logic        rw_reg;
    logic        byte_idx_reg;
    logic [13:0] snap_reg;
    logic [7:0]  cur_byte;
    logic [2:0]  bit_sel;
    logic        sda_oe_reg;
    logic [7:0]  config_byte_reg;
    logic        config_valid_reg;
    logic        sample_req_reg;
    logic        busy_reg;

    assign line_raw = {sda, scl};

    // Per line: synchronizer, then accept a new level only after FILT_LEN equal samples.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_cond
            logic [SYNC_STAGES-1:0] sync_reg;
            logic [FILT_LEN-1:0]    hist_reg;
            logic                   filt_reg;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    sync_reg <= '1;
                    hist_reg <= '1;
                    filt_reg <= 1'b1;
                end else begin
                    sync_reg <= {sync_reg[SYNC_STAGES-2:0], line_raw[gi]};
                    hist_reg <= {hist_reg[FILT_LEN-2:0], sync_reg[SYNC_STAGES-1]};
                    if (&hist_reg) begin
                        filt_reg <= 1'b1;
                    end else if (~|hist_reg) begin
                        filt_reg <= 1'b0;
                    end
                end
            end

            assign line_f[gi] = filt_reg;
        end
    endgenerate

    assign scl_f = line_f[0];
    assign sda_f = line_f[1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scl_prev_reg <= 1'b1;
            sda_prev_reg <= 1'b1;
        end else begin
            scl_prev_reg <= scl_f;
            sda_prev_reg <= sda_f;
        end
    end

    assign scl_rise   = scl_f & ~scl_prev_reg;
    assign scl_fall   = ~scl_f & scl_prev_reg;
    assign start_det  = scl_f & scl_prev_reg & sda_prev_reg & ~sda_f;
    assign stop_det   = scl_f & scl_prev_reg & ~sda_prev_reg & sda_f;
    assign shift_next = {shift_reg[6:0], sda_f};
    assign cur_byte   = byte_idx_reg ? snap_reg[7:0]
                                     : {2'b00, snap_reg[13:12], snap_reg[11:8]};
    assign bit_sel    = 3'd7 - bit_cnt_reg[2:0];

    // ACK phases use sda_oe_reg itself to tell "waiting for first fall" from "holding ACK".
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg        <= IDLE;
            bit_cnt_reg      <= 4'd0;
            shift_reg        <= 8'h00;
            rw_reg           <= 1'b0;
            byte_idx_reg     <= 1'b0;
            snap_reg         <= 14'h0000;
            sda_oe_reg       <= 1'b0;
            config_byte_reg  <= 8'h00;
            config_valid_reg <= 1'b0;
            sample_req_reg   <= 1'b0;
            busy_reg         <= 1'b0;
        end else begin
            config_valid_reg <= 1'b0;
            sample_req_reg   <= 1'b0;
            if (start_det) begin
                state_reg   <= ADDR;
                bit_cnt_reg <= 4'd0;
                sda_oe_reg  <= 1'b0;
                busy_reg    <= 1'b0;
            end else if (stop_det) begin
                state_reg  <= IDLE;
                sda_oe_reg <= 1'b0;
                busy_reg   <= 1'b0;
            end else begin
                case (state_reg)
                    IDLE: begin
                        sda_oe_reg <= 1'b0;
                    end
                    ADDR: begin
                        if (scl_rise) begin
                            shift_reg   <= shift_next;
                            bit_cnt_reg <= bit_cnt_reg + 4'd1;
                            if (bit_cnt_reg == 4'd7) begin
                                if (shift_next[7:1] == DEV_ADDR) begin
                                    state_reg <= ADDR_ACK;
                                    busy_reg  <= 1'b1;
                                    rw_reg    <= shift_next[0];
                                    if (shift_next[0]) begin
                                        snap_reg       <= {adc.sample_chan, adc.sample_data};
                                        sample_req_reg <= 1'b1;
                                        byte_idx_reg   <= 1'b0;
                                    end
                                end else begin
                                    state_reg <= IGNORE;
                                end
                            end
                        end
                    end
                    ADDR_ACK: begin
                        if (scl_fall) begin
                            if (!sda_oe_reg) begin
                                sda_oe_reg <= 1'b1;
                            end else if (rw_reg) begin
                                state_reg   <= RD_DATA;
                                bit_cnt_reg <= 4'd0;
                                sda_oe_reg  <= ~cur_byte[7];
                            end else begin
                                state_reg   <= WR_DATA;
                                bit_cnt_reg <= 4'd0;
                                sda_oe_reg  <= 1'b0;
                            end
                        end
                    end
                    WR_DATA: begin
                        if (scl_rise) begin
                            shift_reg   <= shift_next;
                            bit_cnt_reg <= bit_cnt_reg + 4'd1;
                            if (bit_cnt_reg == 4'd7) begin
                                config_byte_reg  <= shift_next;
                                config_valid_reg <= 1'b1;
                                state_reg        <= WR_ACK;
                            end
                        end
                    end
                    WR_ACK: begin
                        if (scl_fall) begin
                            if (!sda_oe_reg) begin
                                sda_oe_reg <= 1'b1;
                            end else begin
                                state_reg   <= WR_DATA;
                                bit_cnt_reg <= 4'd0;
                                sda_oe_reg  <= 1'b0;
                            end
                        end
                    end
                    RD_DATA: begin
                        if (scl_rise) begin
                            bit_cnt_reg <= bit_cnt_reg + 4'd1;
                        end else if (scl_fall) begin
                            if (bit_cnt_reg == 4'd8) begin
                                state_reg   <= RD_ACK;
                                bit_cnt_reg <= 4'd0;
                                sda_oe_reg  <= 1'b0;
                            end else begin
                                sda_oe_reg <= ~cur_byte[bit_sel];
                            end
                        end
                    end
                    RD_ACK: begin
                        // bit_cnt_reg==1 marks "ACK received, next byte starts on this fall".
                        if (scl_rise) begin
                            if (!sda_f) begin
                                byte_idx_reg <= ~byte_idx_reg;
                                bit_cnt_reg  <= 4'd1;
                            end else begin
                                state_reg <= IGNORE;
                                busy_reg  <= 1'b0;
                            end
                        end else if (scl_fall && bit_cnt_reg == 4'd1) begin
                            state_reg   <= RD_DATA;
                            bit_cnt_reg <= 4'd0;
                            sda_oe_reg  <= ~cur_byte[7];
                        end
                    end
                    IGNORE: begin
                        sda_oe_reg <= 1'b0;
                    end
                    default: begin
                        state_reg  <= IDLE;
                        sda_oe_reg <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign sda              = sda_oe_reg ? 1'b0 : 1'bz;
    assign adc.config_byte  = config_byte_reg;
    assign adc.config_valid = config_valid_reg;
    assign adc.sample_req   = sample_req_reg;
    assign adc.busy         = busy_reg;

endmodule

// File: tb/tb_i2c_adc_target.sv
// Bench for i2c_adc_target: bit-banged I2C initiator, scoreboard of expected bus
// responses and config updates, checked by a separate monitor process.
module tb_i2c_adc_target;
    localparam int T = 8;

    typedef struct {
        string name;
        int    val;
    } item_t;

    logic clk     = 1'b0;
    logic rst     = 1'b1;
    logic scl     = 1'b1;
    logic sda_low = 1'b0;
    wire  sda;

    pullup (sda);
    assign sda = sda_low ? 1'b0 : 1'bz;

    i2c_adc_target_if adc_bus ();

    i2c_adc_target #(
        .DEV_ADDR    (7'h28),
        .SYNC_STAGES (2),
        .FILT_LEN    (3)
    ) dut (
        .clk (clk),
        .rst (rst),
        .scl (scl),
        .sda (sda),
        .adc (adc_bus)
    );

    always #5 clk = ~clk;

    int    checks    = 0;
    int    errors    = 0;
    int    req_seen  = 0;
    int    req_exp   = 0;
    int    model_cfg = 0;
    item_t exp_q[$];
    item_t rx_q[$];
    int    exp_cfg_q[$];
    item_t rx_item;
    item_t ex_item;
    int    cfg_exp_val;

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, expv);
        end else begin
            $display("ok   %s value=%0h", name, act);
        end
    endtask

    function automatic item_t mk(input string n, input int v);
        item_t it;
        it.name = n;
        it.val  = v;
        return it;
    endfunction

    // Reference: byte 0 = {00, chan, sample[11:8]}, byte 1 = sample[7:0], alternating.
    function automatic int model_rd_byte(input int chan, input int data, input int idx);
        if (idx == 0) return chan * 16 + data / 256;
        return data % 256;
    endfunction

    // Scoreboard monitor: compares every bus observation and config update.
    always @(negedge clk) begin
        if (rx_q.size() > 0) begin
            rx_item = rx_q.pop_front();
            if (exp_q.size() == 0) begin
                chk({"rx_without_expect_", rx_item.name}, exp_q.size(), 1);
            end else begin
                ex_item = exp_q.pop_front();
                chk(ex_item.name, rx_item.val, ex_item.val);
            end
        end
        if (adc_bus.config_valid) begin
            if (exp_cfg_q.size() == 0) begin
                chk("config_valid_without_expect", exp_cfg_q.size(), 1);
            end else begin
                cfg_exp_val = exp_cfg_q.pop_front();
                chk("config_update", int'(adc_bus.config_byte), cfg_exp_val);
            end
        end
        if (adc_bus.sample_req) req_seen++;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog time limit reached checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic put_bit(input bit b, input bit glitch, output bit seen);
        sda_low = ~b;
        if (glitch) begin
            wait_clk(T / 2);
            scl = 1'b1;
            wait_clk(1);
            scl = 1'b0;
            wait_clk(T - T / 2 - 1);
        end else begin
            wait_clk(T);
        end
        scl = 1'b1;
        wait_clk(T);
        seen = sda;
        wait_clk(T);
        scl = 1'b0;
        wait_clk(T);
    endtask

    task automatic i2c_start();
        sda_low = 1'b0;
        wait_clk(T);
        scl = 1'b1;
        wait_clk(T);
        sda_low = 1'b1;
        wait_clk(T);
        scl = 1'b0;
        wait_clk(T);
    endtask

    task automatic i2c_stop();
        sda_low = 1'b1;
        wait_clk(T);
        scl = 1'b1;
        wait_clk(T);
        sda_low = 1'b0;
        wait_clk(2 * T);
    endtask

    task automatic send_byte(input logic [7:0] b, input int gbit);
        bit s;
        for (int i = 7; i >= 0; i--) put_bit(b[i], i == gbit, s);
        put_bit(1'b1, 1'b0, s);
        rx_q.push_back(mk("ack", int'(s)));
    endtask

    task automatic recv_byte(input bit ack_it, input int gbit);
        bit s;
        logic [7:0] v;
        for (int i = 7; i >= 0; i--) begin
            put_bit(1'b1, i == gbit, s);
            v[i] = s;
        end
        rx_q.push_back(mk("rd_byte", int'(v)));
        put_bit(~ack_it, 1'b0, s);
    endtask

    task automatic set_sample(input logic [11:0] d, input logic [1:0] c);
        adc_bus.sample_data = d;
        adc_bus.sample_chan = c;
    endtask

    task automatic run_txn(input logic [7:0] addr, input int nbytes, input int fixed_data,
                           input int gbit, input bit mid_change, input bit do_stop);
        bit         addressed;
        int         chan0;
        int         data0;
        logic [7:0] d;
        addressed = (addr[7:1] == 7'h28);
        chan0     = int'(adc_bus.sample_chan);
        data0     = int'(adc_bus.sample_data);
        $display("txn addr=%02h bytes=%0d glitch=%0d", addr, nbytes, gbit);
        i2c_start();
        exp_q.push_back(mk("addr_ack", addressed ? 0 : 1));
        if (addressed && addr[0]) req_exp++;
        send_byte(addr, -1);
        chk("busy_after_addr", int'(adc_bus.busy), int'(addressed));
        for (int k = 0; k < nbytes; k++) begin
            if (addr[0]) begin
                if (mid_change) set_sample(12'($urandom), 2'($urandom));
                exp_q.push_back(mk("rd_byte", addressed ? model_rd_byte(chan0, data0, k % 2) : 8'hFF));
                recv_byte(k != nbytes - 1, (k == 0) ? gbit : -1);
            end else begin
                d = (fixed_data >= 0) ? 8'(fixed_data) : 8'($urandom);
                exp_q.push_back(mk("wr_ack", addressed ? 0 : 1));
                if (addressed) begin
                    exp_cfg_q.push_back(int'(d));
                    model_cfg = int'(d);
                end
                send_byte(d, (k == 0) ? gbit : -1);
            end
        end
        if (addr[0]) chk("busy_after_nack", int'(adc_bus.busy), 0);
        else         chk("busy_after_write", int'(adc_bus.busy), int'(addressed));
        if (do_stop) begin
            i2c_stop();
            chk("busy_after_stop", int'(adc_bus.busy), 0);
            chk("config_byte", int'(adc_bus.config_byte), model_cfg);
        end
    endtask

    initial begin
        logic [7:0] a;
        int         sel;
        int         g;
        set_sample(12'h000, 2'd0);
        wait_clk(4);
        chk("rst_config_byte", int'(adc_bus.config_byte), 0);
        chk("rst_config_valid", int'(adc_bus.config_valid), 0);
        chk("rst_sample_req", int'(adc_bus.sample_req), 0);
        chk("rst_busy", int'(adc_bus.busy), 0);
        chk("rst_sda_released", int'(sda), 1);
        rst = 1'b0;
        wait_clk(2 * T);

        run_txn(8'h50, 1, 8'h10, -1, 1'b0, 1'b1);
        set_sample(12'hA5C, 2'd2);
        run_txn(8'h51, 2, -1, -1, 1'b0, 1'b1);
        run_txn(8'hA0, 1, 8'h77, -1, 1'b0, 1'b1);
        run_txn(8'h50, 1, 8'h10, -1, 1'b0, 1'b0);
        set_sample(12'h3C7, 2'd1);
        run_txn(8'h51, 2, -1, -1, 1'b0, 1'b1);
        set_sample(12'hA5C, 2'd2);
        run_txn(8'h51, 4, -1, -1, 1'b1, 1'b1);
        run_txn(8'h50, 2, -1, 3, 1'b0, 1'b1);
        set_sample(12'h0F1, 2'd3);
        run_txn(8'h51, 3, -1, 5, 1'b0, 1'b1);

        // Reset while the target is driving the first read bit low.
        set_sample(12'hA5C, 2'd2);
        $display("txn addr=51 reset mid-read");
        i2c_start();
        exp_q.push_back(mk("addr_ack", 0));
        req_exp++;
        send_byte(8'h51, -1);
        wait_clk(4);
        chk("sda_driven_before_rst", int'(sda), 0);
        rst = 1'b1;
        #1;
        chk("sda_released_async", int'(sda), 1);
        chk("busy_in_rst", int'(adc_bus.busy), 0);
        wait_clk(2);
        rst = 1'b0;
        model_cfg = 0;
        chk("config_after_rst", int'(adc_bus.config_byte), 0);
        exp_q.push_back(mk("rd_byte_after_rst", 8'hFF));
        recv_byte(1'b0, -1);
        i2c_stop();
        chk("busy_after_rst_stop", int'(adc_bus.busy), 0);

        for (int n = 0; n < 12; n++) begin
            sel = int'($urandom_range(0, 3));
            g   = int'($urandom_range(0, 9));
            if (g > 7) g = -1;
            set_sample(12'($urandom), 2'($urandom));
            case (sel)
                0: run_txn(8'h50, int'($urandom_range(1, 3)), -1, g, 1'b0, 1'b1);
                1: run_txn(8'h51, int'($urandom_range(1, 4)), -1, g, 1'b0, 1'b1);
                2: begin
                    do a = 8'($urandom); while (a[7:1] == 7'h28);
                    run_txn(a, int'($urandom_range(1, 2)), -1, g, 1'b0, 1'b1);
                end
                default: run_txn(8'h51, int'($urandom_range(2, 4)), -1, g, 1'b1, 1'b1);
            endcase
        end

        wait_clk(4 * T);
        chk("sample_req_count", req_seen, req_exp);
        chk("unmatched_expects", exp_q.size(), 0);
        chk("unmatched_rx", rx_q.size(), 0);
        chk("pending_config_updates", exp_cfg_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
